// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// Carries the instruction opcode in and every datapath enable/select out.
// master: control FSM side; slave: datapath side.
interface multicycle_control_if;
   logic [5:0] opcode;        // instruction[31:26] from the instruction register
   logic       pc_write;      // unconditional PC load
   logic       pc_write_cond; // PC load when ALU zero (beq)
   logic       i_or_d;        // memory address: 0 PC, 1 ALUOut
   logic       mem_read;      // memory read strobe
   logic       mem_write;     // memory write strobe
   logic       mem_to_reg;    // register write data: 0 ALUOut, 1 MDR
   logic       ir_write;      // instruction register load
   logic [1:0] pc_source;     // 00 ALU result, 01 ALUOut, 10 jump target
   logic [1:0] alu_op;        // 00 add, 01 subtract, 10 decode funct
   logic       alu_src_a;     // 0 PC, 1 register A
   logic [1:0] alu_src_b;     // 00 reg B, 01 const 4, 10 imm, 11 imm<<2
   logic       reg_write;     // register file write enable
   logic       reg_dst;       // dest register: 0 rt, 1 rd
   logic       illegal_op;    // unsupported opcode seen in DECODE
   logic       instr_done;    // last cycle of the current instruction

   modport master (
      input  opcode,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
             ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
             reg_dst, illegal_op, instr_done
   );

   modport slave (
      output opcode,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
             ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
             reg_dst, illegal_op, instr_done
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core (Moore, registered control word).
// Latency: lw 5, sw/R/addi 4, beq/j 3, illegal 2 cycles from FETCH to instr_done.
// Backpressure: none; one state step per clock, the datapath never stalls it.
//
// Ports: clk, reset (async, active-high, forces FETCH); bus (multicycle_control_if
// master): opcode in, all datapath enables / mux selects / alu_op out.
// Build option: define MULTICYCLE_ADDI_EN to decode addi (001000) through
// ADDI_EXEC/ADDI_WB; otherwise addi is illegal and codes 10/11 are unreachable.
module multicycle_control #(
   parameter int STATE_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = STATE_W'(0),
      S_DECODE    = STATE_W'(1),
      S_MEM_ADDR  = STATE_W'(2),
      S_MEM_READ  = STATE_W'(3),
      S_MEM_WB    = STATE_W'(4),
      S_MEM_WRITE = STATE_W'(5),
      S_EXECUTE   = STATE_W'(6),
      S_R_WB      = STATE_W'(7),
      S_BRANCH    = STATE_W'(8),
      S_JUMP      = STATE_W'(9),
      S_ADDI_EXEC = STATE_W'(10),
      S_ADDI_WB   = STATE_W'(11)
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       done;
   } ctrl_t;

   state_t state;
   state_t nxt;
   ctrl_t  ctrl_q;

   function automatic logic op_legal(input logic [5:0] op);
      logic ok;
      ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_BEQ) || (op == OP_J);
`ifdef MULTICYCLE_ADDI_EN
      ok = ok || (op == OP_ADDI);
`endif
      return ok;
   endfunction

   // Control word for a state; unknown codes decode to all-zero.
   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.alu_src_b = 2'b01;
            c.pc_write  = 1'b1;
         end
         S_DECODE:    c.alu_src_b = 2'b11;   // branch target into ALUOut
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.done       = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
            c.done      = 1'b1;
         end
         S_EXECUTE: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         S_R_WB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
            c.done      = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
            c.done          = 1'b1;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
            c.done      = 1'b1;
         end
`ifdef MULTICYCLE_ADDI_EN
         S_ADDI_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_ADDI_WB: begin
            c.reg_write = 1'b1;
            c.done      = 1'b1;
         end
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic state_t next_state(input state_t s, input logic [5:0] op);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH: n = S_DECODE;
         S_DECODE: begin
            if (op == OP_LW || op == OP_SW) n = S_MEM_ADDR;
            else if (op == OP_R)            n = S_EXECUTE;
            else if (op == OP_BEQ)          n = S_BRANCH;
            else if (op == OP_J)            n = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
            else if (op == OP_ADDI)         n = S_ADDI_EXEC;
`endif
            else                            n = S_FETCH;   // illegal: NOP, PC already +4
         end
         // IR is stable here, so the opcode can be looked at again.
         S_MEM_ADDR:  n = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  n = S_MEM_WB;
         S_EXECUTE:   n = S_R_WB;
`ifdef MULTICYCLE_ADDI_EN
         S_ADDI_EXEC: n = S_ADDI_WB;
`endif
         default:     n = S_FETCH;   // last states and unreachable codes
      endcase
      return n;
   endfunction

   always_comb nxt = next_state(state, bus.opcode);

   // Control word is computed from the next state so it is registered
   // alongside the state and still depends on the state alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_FETCH;
         ctrl_q <= decode(S_FETCH);
      end else begin
         state  <= nxt;
         ctrl_q <= decode(nxt);
      end
   end

   // The opcode only becomes valid once IR has loaded at the end of FETCH,
   // so the illegal flag is formed from the registered state and live opcode.
   logic illegal;
   assign illegal = (state == S_DECODE) && !op_legal(bus.opcode);

   assign bus.pc_write      = ctrl_q.pc_write;
   assign bus.pc_write_cond = ctrl_q.pc_write_cond;
   assign bus.i_or_d        = ctrl_q.i_or_d;
   assign bus.mem_read      = ctrl_q.mem_read;
   assign bus.mem_write     = ctrl_q.mem_write;
   assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
   assign bus.ir_write      = ctrl_q.ir_write;
   assign bus.pc_source     = ctrl_q.pc_source;
   assign bus.alu_op        = ctrl_q.alu_op;
   assign bus.alu_src_a     = ctrl_q.alu_src_a;
   assign bus.alu_src_b     = ctrl_q.alu_src_b;
   assign bus.reg_write     = ctrl_q.reg_write;
   assign bus.reg_dst       = ctrl_q.reg_dst;
   assign bus.illegal_op    = illegal;
   assign bus.instr_done    = ctrl_q.done | illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected control-word sequences,
// checked every cycle at the falling edge, directed cases then random programs.
module tb_multicycle_control;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_control_if bus ();

   multicycle_control #(.STATE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

   typedef logic [17:0] vec_t;

   int n_total = 0;
   int n_pass  = 0;
   vec_t exp_q[$];

   // Field order: pc_write pc_write_cond i_or_d mem_read mem_write mem_to_reg
   // ir_write pc_source alu_op alu_src_a alu_src_b reg_write reg_dst illegal done
   function automatic vec_t mk(bit pcw, bit pcwc, bit iod, bit mr, bit mw, bit m2r,
                               bit irw, bit [1:0] pcs, bit [1:0] aop, bit asa,
                               bit [1:0] asb, bit rw, bit rd, bit ill, bit dn);
      return {pcw, pcwc, iod, mr, mw, m2r, irw, pcs, aop, asa, asb, rw, rd, ill, dn};
   endfunction

   function automatic vec_t dut_vec();
      return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
              bus.mem_write, bus.mem_to_reg, bus.ir_write, bus.pc_source,
              bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.reg_write,
              bus.reg_dst, bus.illegal_op, bus.instr_done};
   endfunction

   function automatic bit addi_en();
`ifdef MULTICYCLE_ADDI_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit supported(logic [5:0] op);
      return op == LW || op == SW || op == RT || op == BEQ || op == JMP ||
             (op == ADDI && addi_en());
   endfunction

   function automatic int latency(logic [5:0] op);
      if (!supported(op)) return 2;
      case (op)
         LW:      return 5;
         SW, RT:  return 4;
         ADDI:    return 4;
         default: return 3;   // beq, j
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   // Instruction-level model: the control word seen on each cycle of one opcode.
   task automatic push_seq(input logic [5:0] op);
      vec_t f, d;
      f = mk(1,0,0,1,0,0,1,2'b00,2'b00,0,2'b01,0,0,0,0);
      d = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0,0,0);
      exp_q.delete();
      exp_q.push_back(f);
      if (!supported(op)) begin
         exp_q.push_back(d | mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,0,0,1,1));
         return;
      end
      exp_q.push_back(d);
      case (op)
         LW: begin
            exp_q.push_back(mk(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0));
            exp_q.push_back(mk(0,0,1,1,0,0,0,2'b00,2'b00,0,2'b00,0,0,0,0));
            exp_q.push_back(mk(0,0,0,0,0,1,0,2'b00,2'b00,0,2'b00,1,0,0,1));
         end
         SW: begin
            exp_q.push_back(mk(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0));
            exp_q.push_back(mk(0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0,0,1));
         end
         RT: begin
            exp_q.push_back(mk(0,0,0,0,0,0,0,2'b00,2'b10,1,2'b00,0,0,0,0));
            exp_q.push_back(mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,1,0,1));
         end
         BEQ: exp_q.push_back(mk(0,1,0,0,0,0,0,2'b01,2'b01,1,2'b00,0,0,0,1));
         JMP: exp_q.push_back(mk(1,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,0,0,0,1));
         default: begin   // addi
            exp_q.push_back(mk(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0));
            exp_q.push_back(mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,0,0,1));
         end
      endcase
   endtask

   // Runs one instruction; abort_at >= 0 asserts reset during that cycle.
   task automatic run_instr(input logic [5:0] op, input int abort_at);
      int done_at;
      int n;
      done_at = 0;
      push_seq(op);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.opcode = op;
         #1;
         chk($sformatf("op%02h_cycle%0d", op, i + 1), dut_vec(), exp_q[i]);
         chk($sformatf("op%02h_exclusive%0d", op, i + 1),
             {30'd0, bus.mem_read & bus.mem_write, bus.reg_write & bus.pc_write}, 32'd0);
         if (bus.instr_done && done_at == 0) done_at = i + 1;
         if (i == abort_at) begin
            reset = 1'b1;
            #1;
            chk("abort_fetch_word", dut_vec(), exp_q[0]);
            chk("abort_mem_read", bus.mem_read, 1);
            chk("abort_ir_write", bus.ir_write, 1);
            chk("abort_pc_write", bus.pc_write, 1);
            chk("abort_alu_src_b", bus.alu_src_b, 2'b01);
            @(posedge clk);
            #1;
            chk("abort_held", dut_vec(), exp_q[0]);
            #1 reset = 1'b0;
            return;
         end
      end
      chk($sformatf("op%02h_latency", op), done_at, latency(op));
   endtask

   initial begin
      logic [5:0] op;
      logic [5:0] pool [6];
      pool[0] = LW; pool[1] = SW; pool[2] = RT;
      pool[3] = BEQ; pool[4] = JMP; pool[5] = ADDI;
      bus.opcode = RT;

      // Reset state: FETCH control word.
      #12;
      chk("reset_word", dut_vec(), mk(1,0,0,1,0,0,1,2'b00,2'b00,0,2'b01,0,0,0,0));
      @(posedge clk);
      #2 reset = 1'b0;

      // Pin the model against hand-worked facts.
      push_seq(LW);
      chk("model_lw_len", exp_q.size(), 5);
      chk("model_lw_m2r", exp_q[4][12], 1);
      push_seq(BEQ);
      chk("model_beq_aluop", exp_q[2][8:7], 2'b01);

      run_instr(LW, -1);
      run_instr(RT, -1);
      run_instr(BEQ, -1);
      run_instr(SW, -1);
      run_instr(JMP, -1);
      run_instr(ADDI, -1);
      run_instr(6'b111111, -1);
      run_instr(LW, 3);          // reset in MEM_READ
      run_instr(LW, -1);

      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 6) == 6) begin
            do op = 6'($urandom_range(0, 63)); while (supported(op));
         end else begin
            op = pool[$urandom_range(0, 5)];
         end
         run_instr(op, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
